spi_mem_loader: RTL and testbench

Processor-side SPI load receiver for tiny_processor. Samples the host serial stream `mosi` under the two active-low chip selects `csi` (instruction memory) and `csd` (data memory). Deserialises MSB-first words and emits one-cycle write strobes into the instruction or data memory with auto-incrementing addresses. Sits between the `uio_in` pads and the memory write ports, and is active only while the processor is halted (`proc_en` low).

---
 rtl/spi_mem_loader.sv | 153 +++++++++++++++
 tb/tb_spi_mem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
// SPI load receiver: deserialises MSB-first words under csi/csd into instruction/data memory writes.
// Optional start-address header per frame when LOADER_ADDR_HDR_EN is defined.
module spi_mem_loader #(
  parameter int unsigned IW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_en,
  input  logic          csi,
  input  logic          csd,
  input  logic          mosi,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          busy,
  output logic          load_done,
  output logic          err
);

  localparam int unsigned SW = (IW > DW) ? IW : DW;
  localparam int unsigned MW = (SW > AW) ? SW : AW;
  localparam int unsigned CW = $clog2(MW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_I, SHIFT_D, FAULT} state_t;

  state_t         state, state_nxt;
  logic [MW-2:0]  shreg;
  logic [CW-1:0]  bit_cnt;
  logic [AW-1:0]  addr_cnt;
  logic           wrote;
  logic [MW-1:0]  shreg_nxt_c;
  logic           sample_c;
  logic           last_bit_c;
  logic           frame_end_c;
  logic           hdr_phase_c;
  logic           both_low_c;

`ifdef LOADER_ADDR_HDR_EN
  logic hdr;
  assign hdr_phase_c = hdr;
`else
  assign hdr_phase_c = 1'b0;
`endif

  assign both_low_c = !csi && !csd;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus sample/word-boundary decode; a bit is sampled whenever the next state is a shift state.
  always_comb begin
    state_nxt   = state;
    sample_c    = 1'b0;
    last_bit_c  = 1'b0;
    frame_end_c = 1'b0;
    shreg_nxt_c = {shreg, mosi};
    case (state)
      IDLE: begin
        if (both_low_c)              state_nxt = FAULT;
        else if (!proc_en && !csi)   state_nxt = SHIFT_I;
        else if (!proc_en && !csd)   state_nxt = SHIFT_D;
      end
      SHIFT_I: begin
        if (both_low_c)              state_nxt = FAULT;
        else if (proc_en || csi)     state_nxt = IDLE;
      end
      SHIFT_D: begin
        if (both_low_c)              state_nxt = FAULT;
        else if (proc_en || csd)     state_nxt = IDLE;
      end
      FAULT: begin
        if (csi && csd)              state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    sample_c = (state_nxt == SHIFT_I) || (state_nxt == SHIFT_D);
    if (hdr_phase_c)                last_bit_c = (bit_cnt == CW'(AW - 1));
    else if (state_nxt == SHIFT_I)  last_bit_c = (bit_cnt == CW'(IW - 1));
    else                            last_bit_c = (bit_cnt == CW'(DW - 1));
    // proc_en abort suppresses load_done even if the select rises on the same edge
    frame_end_c = ((state == SHIFT_I) || (state == SHIFT_D)) && (state_nxt == IDLE)
                  && !proc_en && wrote;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      addr_cnt   <= '0;
      wrote      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_ADDR_HDR_EN
      hdr        <= 1'b1;
`endif
    end else begin
      imem_we   <= 1'b0;
      dmem_we   <= 1'b0;
      busy      <= sample_c;
      load_done <= frame_end_c;
      if (state_nxt == FAULT) err <= 1'b1;
      if (sample_c) begin
        shreg <= shreg_nxt_c[MW-2:0];
        if (last_bit_c) begin
          bit_cnt <= '0;
          if (hdr_phase_c) begin
            addr_cnt <= shreg_nxt_c[AW-1:0];
`ifdef LOADER_ADDR_HDR_EN
            hdr      <= 1'b0;
`endif
          end else begin
            addr_cnt <= addr_cnt + AW'(1);
            wrote    <= 1'b1;
            if (state_nxt == SHIFT_I) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr_cnt;
              imem_wdata <= shreg_nxt_c[IW-1:0];
            end else begin
              dmem_we    <= 1'b1;
              dmem_addr  <= addr_cnt;
              dmem_wdata <= shreg_nxt_c[DW-1:0];
            end
          end
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else begin
        // outside a frame: partial word dropped, counters ready for the next frame entry
        bit_cnt  <= '0;
        addr_cnt <= '0;
        wrote    <= 1'b0;
`ifdef LOADER_ADDR_HDR_EN
        hdr      <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed self-checking bench for spi_mem_loader (default build; header scenario under LOADER_ADDR_HDR_EN).
module tb_spi_mem_loader;

  logic       clk = 1'b0;
  logic       rst, proc_en, csi, csd, mosi;
  logic       imem_we, dmem_we, busy, load_done, err;
  logic [3:0] imem_addr, dmem_addr;
  logic [7:0] imem_wdata, dmem_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int iw_cnt = 0;
  int dw_cnt = 0;
  int ld_cnt = 0;

  spi_mem_loader #(.IW(8), .DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .proc_en(proc_en), .csi(csi), .csd(csd), .mosi(mosi),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) iw_cnt++;
    if (dmem_we === 1'b1) dw_cnt++;
    if (load_done === 1'b1) ld_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; proc_en = 1'b0; csi = 1'b1; csd = 1'b1; mosi = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({imem_we, dmem_we, busy, load_done, err} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000", {imem_we, dmem_we, busy, load_done, err});
    end
    n_cmp++;
    if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata} !== 24'h0) begin
      n_err++; $display("FAIL reset_buses got %h want 000000", {imem_addr, imem_wdata, dmem_addr, dmem_wdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_imem_words();
    int ld0;
    ld0 = ld_cnt;
    csi = 1'b0;
    send_bits(8'hA5, 8);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 4'd0, 8'hA5}) begin
      n_err++; $display("FAIL imem_w0 got we=%b a=%0d d=%h want we=1 a=0 d=a5", imem_we, imem_addr, imem_wdata);
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL imem_busy got %b want 1", busy); end
    send_bits(8'h3C, 1);
    n_cmp++;
    if ({imem_we, imem_wdata} !== {1'b0, 8'hA5}) begin
      n_err++; $display("FAIL imem_hold got we=%b d=%h want we=0 d=a5", imem_we, imem_wdata);
    end
    send_bits(8'h3C, 7);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 4'd1, 8'h3C}) begin
      n_err++; $display("FAIL imem_w1 got we=%b a=%0d d=%h want we=1 a=1 d=3c", imem_we, imem_addr, imem_wdata);
    end
    n_cmp++;
    if (dmem_we !== 1'b0) begin n_err++; $display("FAIL imem_excl got dmem_we=%b want 0", dmem_we); end
    csi = 1'b1;
    tick();
    n_cmp++;
    if ({load_done, busy} !== 2'b10) begin
      n_err++; $display("FAIL imem_done got ld=%b busy=%b want ld=1 busy=0", load_done, busy);
    end
    tick();
    n_cmp++;
    if (ld_cnt - ld0 !== 1) begin n_err++; $display("FAIL imem_done_pulses got %0d want 1", ld_cnt - ld0); end
  endtask

  task automatic test_dmem_wrap();
    logic [7:0] v;
    int ld0;
    ld0 = ld_cnt;
    csd = 1'b0;
    for (int w = 0; w < 17; w++) begin
      v = 8'(8'h40 + w);
      send_bits(v, 8);
      n_cmp++;
      if ({dmem_we, dmem_addr, dmem_wdata, imem_we} !== {1'b1, 4'(w % 16), v, 1'b0}) begin
        n_err++;
        $display("FAIL dmem_word%0d got we=%b a=%0d d=%h iwe=%b want we=1 a=%0d d=%h iwe=0",
                 w, dmem_we, dmem_addr, dmem_wdata, imem_we, w % 16, v);
      end
    end
    csd = 1'b1;
    tick();
    n_cmp++;
    if (load_done !== 1'b1) begin n_err++; $display("FAIL dmem_done got %b want 1", load_done); end
    tick();
    n_cmp++;
    if (ld_cnt - ld0 !== 1) begin n_err++; $display("FAIL dmem_done_pulses got %0d want 1", ld_cnt - ld0); end
  endtask

  task automatic test_partial();
    int iw0, ld0;
    iw0 = iw_cnt; ld0 = ld_cnt;
    csi = 1'b0;
    send_bits(8'hFF, 5);
    csi = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL partial_busy got %b want 0", busy); end
    tick(); tick();
    n_cmp++;
    if ({iw_cnt - iw0, ld_cnt - ld0} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL partial_writes got we=%0d ld=%0d want 0 0", iw_cnt - iw0, ld_cnt - ld0);
    end
  endtask

  task automatic test_fault();
    int iw0, dw0;
    iw0 = iw_cnt; dw0 = dw_cnt;
    csd = 1'b0;
    send_bits(8'hE0, 3);
    csi = 1'b0;
    tick();
    n_cmp++;
    if ({err, busy} !== 2'b10) begin n_err++; $display("FAIL fault_enter got err=%b busy=%b want 1 0", err, busy); end
    send_bits(8'hFF, 8);
    csi = 1'b1;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL fault_stay got busy=%b want 0", busy); end
    n_cmp++;
    if ({iw_cnt - iw0, dw_cnt - dw0} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL fault_writes got i=%0d d=%0d want 0 0", iw_cnt - iw0, dw_cnt - dw0);
    end
    csd = 1'b1;
    tick();
    csd = 1'b0;
    send_bits(8'h5A, 8);
    n_cmp++;
    if ({dmem_we, dmem_addr, dmem_wdata, err} !== {1'b1, 4'd0, 8'h5A, 1'b1}) begin
      n_err++; $display("FAIL fault_recover got we=%b a=%0d d=%h err=%b want 1 0 5a 1", dmem_we, dmem_addr, dmem_wdata, err);
    end
    csd = 1'b1;
    tick();
    n_cmp++;
    if (load_done !== 1'b1) begin n_err++; $display("FAIL fault_recover_done got %b want 1", load_done); end
    tick();
  endtask

  task automatic test_proc_en();
    int dw0, ld0;
    dw0 = dw_cnt; ld0 = ld_cnt;
    proc_en = 1'b1;
    csd = 1'b0;
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    n_cmp++;
    if ({busy, 32'(dw_cnt - dw0)} !== {1'b0, 32'd0}) begin
      n_err++; $display("FAIL proc_en_inert got busy=%b writes=%0d want 0 0", busy, dw_cnt - dw0);
    end
    csd = 1'b1; proc_en = 1'b0;
    tick();
    csd = 1'b0;
    send_bits(8'h77, 8);
    n_cmp++;
    if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 4'd0, 8'h77}) begin
      n_err++; $display("FAIL proc_en_w0 got we=%b a=%0d d=%h want 1 0 77", dmem_we, dmem_addr, dmem_wdata);
    end
    send_bits(8'hF0, 4);
    proc_en = 1'b1;
    tick();
    n_cmp++;
    if ({busy, load_done} !== 2'b00) begin
      n_err++; $display("FAIL proc_en_abort got busy=%b ld=%b want 0 0", busy, load_done);
    end
    send_bits(8'h0F, 4);
    csd = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({32'(dw_cnt - dw0), 32'(ld_cnt - ld0)} !== {32'd1, 32'd0}) begin
      n_err++; $display("FAIL proc_en_counts got w=%0d ld=%0d want 1 0", dw_cnt - dw0, ld_cnt - ld0);
    end
    proc_en = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_frame();
    int iw0;
    iw0 = iw_cnt;
    csi = 1'b0;
    send_bits(8'hFF, 6);
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy, err, imem_we} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid got busy=%b err=%b we=%b want 000", busy, err, imem_we);
    end
    rst = 1'b0; csi = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (iw_cnt - iw0 !== 0) begin n_err++; $display("FAIL rst_mid_writes got %0d want 0", iw_cnt - iw0); end
  endtask

`ifdef LOADER_ADDR_HDR_EN
  task automatic test_header();
    csi = 1'b0;
    send_bits(8'h0E, 4);
    send_bits(8'h11, 8);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 4'd14, 8'h11}) begin
      n_err++; $display("FAIL hdr_w0 got we=%b a=%0d d=%h want 1 14 11", imem_we, imem_addr, imem_wdata);
    end
    send_bits(8'h22, 8);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 4'd15, 8'h22}) begin
      n_err++; $display("FAIL hdr_w1 got we=%b a=%0d d=%h want 1 15 22", imem_we, imem_addr, imem_wdata);
    end
    csi = 1'b1;
    tick();
    n_cmp++;
    if (load_done !== 1'b1) begin n_err++; $display("FAIL hdr_done got %b want 1", load_done); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef LOADER_ADDR_HDR_EN
    test_header();
`else
    test_imem_words();
    test_dmem_wrap();
    test_partial();
    test_proc_en();
    test_fault();
    test_rst_mid_frame();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
